mul_seq_ctrl: RTL and testbench

//  Moore FSM that sequences the 16-bit repeated-addition multiplier datapath.
//  - Datapath blocks: A register, P accumulator, B down-counter, adder, zero compare.
//  - Drives lda/ldb/ldp/clrp/decb and reads eqz (B == 0).
//  - Runs a four-phase start/done handshake with the host.
//  - Tells the host which operand to present on data_in: A first, then B.

---
 rtl/mul_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl
//   Moore controller for a 16-bit repeated-addition multiplier datapath
//   (A register, P accumulator, B down-counter, adder, B==0 compare).
//   The product is formed by adding A into P once per decrement of B until
//   B reaches zero. The host uses a four-phase start/done handshake.
//
// Handshake: the host raises start (level) and holds it. The controller
//   loads A (op_sel=0) then B (op_sel=1), iterates, and raises done.
//   done stays high while start stays high. When start drops, the
//   controller returns to IDLE on the next cycle. start changes while busy
//   are ignored.
//
// Optional feature (macro MUL_TIMEOUT_EN):
//   If iter_cnt reaches MAX_ITER in CHECK with B still non-zero, the
//   controller aborts to DONE with err=1. Without the macro, err is a
//   constant 0 and the loop runs until eqz=1.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active-high
//   start     in   host request (level)
//   eqz       in   datapath B counter == 0
//   lda       out  load A from data_in
//   ldb       out  load B counter from data_in
//   clrp      out  clear P accumulator
//   ldp       out  P <= P + A
//   decb      out  B <= B - 1
//   op_sel    out  0: host presents A on data_in, 1: host presents B
//   busy      out  high in every state except IDLE and DONE
//   done      out  product valid in P
//   err       out  timeout abort flag
//   iter_cnt  out  number of ACC cycles in the current operation
//   state_dbg out  current FSM state encoding (debug visibility)
// -----------------------------------------------------------------------------
module mul_seq_ctrl #(
   parameter int                CNT_W    = 16,
   // Default is the all-ones value of the counter (16'hFFFF at CNT_W=16).
   parameter logic [CNT_W-1:0]  MAX_ITER = {CNT_W{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             eqz,
   output logic             lda,
   output logic             ldb,
   output logic             clrp,
   output logic             ldp,
   output logic             decb,
   output logic             op_sel,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] iter_cnt,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      CHECK  = 3'd3,
      ACC    = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t state, state_next;

`ifdef MUL_TIMEOUT_EN
   localparam logic TIMEOUT_EN = 1'b1;
`else
   localparam logic TIMEOUT_EN = 1'b0;
`endif

   // Abort condition, only meaningful in CHECK when B is still non-zero.
   logic timeout_hit;
   assign timeout_hit = TIMEOUT_EN && (iter_cnt == MAX_ITER);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state and Moore output decode
   always_comb begin
      state_next = state;
      lda        = 1'b0;
      ldb        = 1'b0;
      clrp       = 1'b0;
      ldp        = 1'b0;
      decb       = 1'b0;
      op_sel     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = LOAD_A;
         end
         LOAD_A: begin
            lda        = 1'b1;
            busy       = 1'b1;
            state_next = LOAD_B;
         end
         LOAD_B: begin
            ldb        = 1'b1;
            clrp       = 1'b1;
            op_sel     = 1'b1;
            busy       = 1'b1;
            state_next = CHECK;
         end
         CHECK: begin
            busy   = 1'b1;
            op_sel = 1'b1;
            // eqz has priority: a finished count never reports a timeout.
            if (eqz)              state_next = DONE;
            else if (timeout_hit) state_next = DONE;
            else                  state_next = ACC;
         end
         ACC: begin
            ldp        = 1'b1;
            decb       = 1'b1;
            busy       = 1'b1;
            state_next = CHECK;
         end
         DONE: begin
            done = 1'b1;
            // Wait for the host to drop start before accepting a new request.
            if (!start) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Iteration counter: cleared when a new operation loads A, wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iter_cnt <= '0;
      end else if (state == LOAD_A) begin
         iter_cnt <= '0;
      end else if (state == ACC) begin
         iter_cnt <= iter_cnt + 1'b1;
      end
   end

`ifdef MUL_TIMEOUT_EN
   logic err_q;
   // err is held through DONE and cleared by the next LOAD_A.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (state == LOAD_A) begin
         err_q <= 1'b0;
      end else if (state == CHECK && !eqz && timeout_hit) begin
         err_q <= 1'b1;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign state_dbg = state;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_seq_ctrl
//   Bench for mul_seq_ctrl with a small behavioural datapath (A, B, P) so
//   that eqz and the product come from real register activity. Directed
//   operations push their hand-computed result into exp_q; a monitor
//   compares each record when done rises.
//   Instantiated with MAX_ITER=4; expected values of the B=10 operation
//   depend on whether MUL_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_mul_seq_ctrl;

   localparam int CNT_W = 16;
   // Record: {err, iter_cnt[15:0], p[31:0], ldp_count[15:0], latency[7:0]}
   localparam int W = 73;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             eqz;
   logic             lda, ldb, clrp, ldp, decb, op_sel, busy, done, err;
   logic [CNT_W-1:0] iter_cnt;
   logic [2:0]       state_dbg;

   logic [15:0] opa = 16'd0;
   logic [15:0] opb = 16'd0;
   logic [15:0] data_in;

   logic [15:0] dp_a = 16'd0;
   logic [15:0] dp_b = 16'd0;
   logic [31:0] dp_p = 32'd0;

   logic [W-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mul_seq_ctrl #(.CNT_W(CNT_W), .MAX_ITER(16'd4)) dut (
      .clk(clk), .rst(rst), .start(start), .eqz(eqz),
      .lda(lda), .ldb(ldb), .clrp(clrp), .ldp(ldp), .decb(decb),
      .op_sel(op_sel), .busy(busy), .done(done), .err(err),
      .iter_cnt(iter_cnt), .state_dbg(state_dbg)
   );

   // Host operand mux and datapath model
   assign data_in = op_sel ? opb : opa;
   assign eqz     = (dp_b == 16'd0);

   always @(posedge clk) begin
      if (lda)  dp_a <= data_in;
      if (ldb)  dp_b <= data_in;
      else if (decb) dp_b <= dp_b - 16'd1;
      if (clrp) dp_p <= 32'd0;
      else if (ldp) dp_p <= dp_p + {16'd0, dp_a};
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   function automatic logic [W-1:0] mk(input logic e, input logic [15:0] it,
                                       input logic [31:0] p, input logic [15:0] np,
                                       input logic [7:0] lat);
      return {e, it, p, np, lat};
   endfunction

   // Monitor: tracks latency/ldp count from LOAD_A and checks on done rise.
   logic [7:0]   mon_lat = 8'd0;
   logic [15:0]  mon_ldp = 16'd0;
   logic         done_q = 1'b0;
   logic [W-1:0] e;

   always @(negedge clk) begin
      if (rst) begin
         mon_lat = 8'd0;
         mon_ldp = 16'd0;
         done_q  = 1'b0;
      end else begin
         if (lda) begin
            mon_lat = 8'd0;
            mon_ldp = 16'd0;
         end else if (mon_lat != 8'hFF) begin
            mon_lat = mon_lat + 8'd1;
         end
         if (ldp) mon_ldp = mon_ldp + 16'd1;
         if (done && !done_q) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("err",      {31'd0, err},  {31'd0, e[72]});
               chk("iter_cnt", {16'd0, iter_cnt}, {16'd0, e[71:56]});
               chk("product",  dp_p, e[55:24]);
               chk("ldp_count",{16'd0, mon_ldp}, {16'd0, e[23:8]});
               chk("latency",  {24'd0, mon_lat}, {24'd0, e[7:0]});
            end
         end
         done_q = done;
      end
   end

   task automatic wait_done(input string name);
      int i;
      for (i = 0; i < 200 && !done; i++) @(negedge clk);
      if (!done) chk({name, "_done_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input string name);
      int i;
      for (i = 0; i < 50 && done; i++) @(negedge clk);
      @(negedge clk);
      chk({name, "_idle"}, {29'd0, state_dbg}, 32'd0);
   endtask

   // Full handshake: push expectation, raise start, wait done, drop start.
   task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [W-1:0] exp_rec);
      exp_q.push_back(exp_rec);
      opa   = a;
      opb   = b;
      start = 1'b1;
      wait_done(name);
      start = 1'b0;
      wait_idle(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_state",   {29'd0, state_dbg}, 32'd0);
      chk("rst_strobes", {27'd0, lda, ldb, clrp, ldp, decb}, 32'd0);
      chk("rst_flags",   {28'd0, op_sel, busy, done, err}, 32'd0);
      chk("rst_iter",    {16'd0, iter_cnt}, 32'd0);
      #2 rst = 1'b0;

      // Reset mid-ACC: A=5, B=9, abort after two ACC pulses
      opa = 16'd5; opb = 16'd9; start = 1'b1;
      n = 0;
      for (int i = 0; i < 50 && n < 2; i++) begin
         @(negedge clk);
         if (ldp) n++;
      end
      chk("midacc_reached", n, 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("midacc_state",   {29'd0, state_dbg}, 32'd0);
      chk("midacc_strobes", {27'd0, lda, ldb, clrp, ldp, decb}, 32'd0);
      chk("midacc_busy",    {31'd0, busy}, 32'd0);
      chk("midacc_iter",    {16'd0, iter_cnt}, 32'd0);
      start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);

      // A=7, B=3: 21, three iterations, 2*3+3 cycles
      do_op("op_7x3", 16'd7, 16'd3, mk(1'b0, 16'd3, 32'd21, 16'd3, 8'd9));
      // A=1234, B=0: no ACC cycles
      do_op("op_1234x0", 16'd1234, 16'd0, mk(1'b0, 16'd0, 32'd0, 16'd0, 8'd3));

      // start held high through DONE (A=3, B=1)
      exp_q.push_back(mk(1'b0, 16'd1, 32'd3, 16'd1, 8'd5));
      opa = 16'd3; opb = 16'd1; start = 1'b1;
      wait_done("hold");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_done", {31'd0, done}, 32'd1);
         chk("hold_no_lda", {31'd0, lda}, 32'd0);
      end
      start = 1'b0;
      @(negedge clk);
      chk("hold_release_idle", {29'd0, state_dbg}, 32'd0);
      chk("hold_release_done", {31'd0, done}, 32'd0);
      // Restart: A=6, B=4 (reaches B==0 exactly as iter_cnt hits 4)
      exp_q.push_back(mk(1'b0, 16'd4, 32'd24, 16'd4, 8'd11));
      opa = 16'd6; opb = 16'd4; start = 1'b1;
      @(negedge clk);
      chk("restart_lda", {31'd0, lda}, 32'd1);
      wait_done("restart");
      start = 1'b0;
      wait_idle("restart");

      // A=3, B=10 against MAX_ITER=4
`ifdef MUL_TIMEOUT_EN
      do_op("op_timeout", 16'd3, 16'd10, mk(1'b1, 16'd4, 32'd12, 16'd4, 8'd11));
`else
      do_op("op_timeout", 16'd3, 16'd10, mk(1'b0, 16'd10, 32'd30, 16'd10, 8'd23));
`endif

      // A=2, B=2 with start toggled while busy; err cleared by LOAD_A
      exp_q.push_back(mk(1'b0, 16'd2, 32'd4, 16'd2, 8'd7));
      opa = 16'd2; opb = 16'd2; start = 1'b1;
      for (int i = 0; i < 10 && !lda; i++) @(negedge clk);
      chk("toggle_lda", {31'd0, lda}, 32'd1);
      @(negedge clk);
      chk("toggle_ldb",      {31'd0, ldb}, 32'd1);
      chk("err_cleared",     {31'd0, err}, 32'd0);
      start = 1'b0;
      @(negedge clk);
      chk("toggle_busy",     {31'd0, busy}, 32'd1);
      @(negedge clk);
      start = 1'b1;
      wait_done("toggle");
      start = 1'b0;
      wait_idle("toggle");

      // No stray operations afterwards
      repeat (10) @(negedge clk);
      chk("final_idle",  {29'd0, state_dbg}, 32'd0);
      chk("final_queue", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
